// File: rtl/lenet_pkg.sv
// Shared LeNet-5 constants for the convolution layers and the width helper
// used to size the window generator counters.
package lenet_pkg;

   localparam int LENET_DATA_W = 8;

   localparam int C1_IMG_W = 32;
   localparam int C1_IMG_H = 32;
   localparam int C1_K     = 5;

   localparam int C3_IMG_W = 14;
   localparam int C3_IMG_H = 14;
   localparam int C3_K     = 5;

   localparam int C5_IMG_W = 5;
   localparam int C5_IMG_H = 5;
   localparam int C5_K     = 5;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } win_state_e;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pixel_shift_reg.sv
// Line buffer for the window generator: a plain shift register whose entry 0
// holds the newest pixel, exposed as one flat bus.
module pixel_shift_reg #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [DATA_W-1:0]       d,
   output logic [DEPTH*DATA_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= {q[(DEPTH-1)*DATA_W-1:0], d};
   end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator over a raster pixel stream with stride,
// row-edge suppression and end-of-frame flags.
module conv_window_gen
   import lenet_pkg::*;
#(
   parameter int DATA_W      = LENET_DATA_W,
   parameter int KERNEL_SIZE = 3,
   parameter int IMG_W       = 14,
   parameter int IMG_H       = 14,
   parameter int STRIDE      = 1
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               clear,
   input  logic                                               in_valid,
   input  logic [DATA_W-1:0]                                  in_data,
   output logic                                               out_valid,
   output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_W-1:0]          out_window,
   output logic [clog2((IMG_H-KERNEL_SIZE)/STRIDE+1)-1:0]     out_row,
   output logic [clog2((IMG_W-KERNEL_SIZE)/STRIDE+1)-1:0]     out_col,
   output logic                                               out_last,
   output logic                                               frame_done,
   output win_state_e                                         state
);

   localparam int K     = KERNEL_SIZE;
   localparam int DEPTH = (K-1)*IMG_W + K;
   localparam int OUT_W = (IMG_W-K)/STRIDE + 1;
   localparam int OUT_H = (IMG_H-K)/STRIDE + 1;
   localparam int COL_W = clog2(IMG_W);
   localparam int ROW_W = clog2(IMG_H);
   localparam int PH_W  = clog2(STRIDE);
   localparam int OC_W  = clog2(OUT_W);
   localparam int OR_W  = clog2(OUT_H);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W-1);
   localparam logic [COL_W-1:0] COL_WIN  = COL_W'(K-1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H-1);
   localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(K-1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STRIDE-1);
   localparam logic [OC_W-1:0]  OC_LAST  = OC_W'(OUT_W-1);
   localparam logic [OR_W-1:0]  OR_LAST  = OR_W'(OUT_H-1);

   logic [DEPTH*DATA_W-1:0] pix_q;
   logic [COL_W-1:0]        in_col;
   logic [ROW_W-1:0]        in_row;
   logic [PH_W-1:0]         col_ph, row_ph;
   logic [OC_W-1:0]         win_col;
   logic [OR_W-1:0]         win_row;
   win_state_e              state_q, state_d;
   logic                    accept, col_end, row_end, frame_end, emit;

   // Handshake: no ready exists. Any cycle with in_valid high and clear low
   // accepts one pixel; out_valid is a one-cycle pulse the sink must take.
   assign accept    = in_valid && !clear;
   assign col_end   = (in_col == COL_LAST);
   assign row_end   = (in_row == ROW_LAST);
   assign frame_end = accept && col_end && row_end;
   assign emit      = accept && (in_row >= ROW_WIN) && (in_col >= COL_WIN) &&
                      (row_ph == '0) && (col_ph == '0);

   pixel_shift_reg #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_shift (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .d   (in_data),
      .q   (pix_q)
   );

   for (genvar r = 0; r < K; r++) begin : g_row
      for (genvar c = 0; c < K; c++) begin : g_col
         assign out_window[(r*K+c)*DATA_W +: DATA_W] =
            pix_q[((K-1-r)*IMG_W + (K-1-c))*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_col     <= '0;
         in_row     <= '0;
         col_ph     <= '0;
         row_ph     <= '0;
         win_col    <= '0;
         win_row    <= '0;
         out_row    <= '0;
         out_col    <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
      end else if (clear) begin
         in_col     <= '0;
         in_row     <= '0;
         col_ph     <= '0;
         row_ph     <= '0;
         win_col    <= '0;
         win_row    <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= emit;
         out_last   <= emit && (win_row == OR_LAST) && (win_col == OC_LAST);
         frame_done <= frame_end;
         if (emit) begin
            out_row <= win_row;
            out_col <= win_col;
            if (win_col == OC_LAST) begin
               win_col <= '0;
               win_row <= (win_row == OR_LAST) ? '0 : win_row + 1'b1;
            end else begin
               win_col <= win_col + 1'b1;
            end
         end
         // Phases restart at every row/frame edge so each row begins aligned.
         if (accept) begin
            if (col_end) begin
               in_col <= '0;
               col_ph <= '0;
               in_row <= row_end ? '0 : in_row + 1'b1;
               if (row_end)
                  row_ph <= '0;
               else if (in_row >= ROW_WIN)
                  row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + 1'b1;
            end else begin
               in_col <= in_col + 1'b1;
               if (in_col >= COL_WIN)
                  col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_FILL;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_FILL;
      end else begin
         unique case (state_q)
            ST_FILL: if (emit && !frame_end) state_d = ST_RUN;
            ST_RUN:  if (frame_end)          state_d = ST_FILL;
            default: state_d = ST_FILL;
         endcase
      end
   end

   always_comb begin
      state = state_q;
   end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Parametrised sliding-window generator for the LeNet-5 convolution layers. It accepts a raster-scan pixel stream (row-major, one pixel per accepted beat) and presents a full KERNEL_SIZE×KERNEL_SIZE window in parallel to the MAC array. It tracks row and column position, suppresses windows that wrap across row edges, supports configurable stride and flags the last window of each frame. One instance serves each conv layer, configured by parameters.

## Interface
- DATA_W, 8: pixel width in bits.
- KERNEL_SIZE, 3: window edge K; 2 ≤ K ≤ min(IMG_W, IMG_H).
- IMG_W, 14: input feature-map width.
- IMG_H, 14: input feature-map height.
- STRIDE, 1: window step in both directions, ≥ 1.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous frame abort; returns counters to the frame start.
- in_valid  in  1  in_data is a valid pixel this cycle; no backpressure.
- in_data  in  DATA_W  pixel, raster order.
- out_valid  out  1  out_window holds a valid window.
- out_window  out  K*K*DATA_W  tap (r,c) at bits [(r*K+c)*DATA_W +: DATA_W]; tap 0 = top-left, r = row top→bottom, c = column left→right.
- out_row  out  clog2(OUT_H) (min 1)  output-map row of the window.
- out_col  out  clog2(OUT_W) (min 1)  output-map column of the window.
- out_last  out  1  final window of the frame.
- frame_done  out  1  one-cycle pulse after the frame's last pixel is accepted.

OUT_W = (IMG_W−K)/STRIDE+1 and OUT_H = (IMG_H−K)/STRIDE+1, using integer division.

## Operation
- **Shift register:** depth D = (K−1)*IMG_W + K, each entry DATA_W wide. On in_valid, every entry shifts up one index (buf[i] ← buf[i−1]) and buf[0] ← in_data. Without in_valid, the register holds.
- **Tap mapping:** tap (r,c) = buf[(K−1−r)*IMG_W + (K−1−c)], so tap (0,0) = buf[D−1].
- **Position counters:** in_col counts 0..IMG_W−1 and in_row counts 0..IMG_H−1, advancing once per accepted pixel and giving that pixel's position. Both wrap to 0 after (IMG_H−1, IMG_W−1), and the next frame then starts immediately.
- **Stride phases:** phase counters col_ph and row_ph count 0..STRIDE−1 and start once in_col ≥ K−1 and in_row ≥ K−1 respectively. Modulo arithmetic is not used.
- **Window emission:** an accepted pixel at (in_row, in_col) produces a window iff in_row ≥ K−1, in_col ≥ K−1, row_ph = 0 and col_ph = 0.
- **Output index counters:** out_col and out_row are incremented per emitted window and wrap at OUT_W and OUT_H.
- **out_last:** asserted with the window whose out_row = OUT_H−1 and out_col = OUT_W−1.
- **FSM:**
  - FILL: the frame start has not yet produced a valid window.
  - RUN: at least one window has been emitted.
  - FILL→RUN on the first window. RUN→FILL on frame wrap.
  - The state is informational and exposed for debug only. Emission is governed by the counters alone.
- **Stale data:** the buffer is never cleared between frames. The emission rule guarantees that no window ever contains pixels from another frame or row.
- **clear:** zeroes all counters and phases and sets state to FILL. The buffer is left untouched. If clear and in_valid are high in the same cycle, clear wins and the pixel is dropped.

## Timing
- **Latency:**
  - out_valid, out_window, out_row, out_col and out_last are valid in the cycle after the edge that accepted the producing pixel.
  - out_valid is a single-cycle pulse per window.
- **out_window hold:** out_window is combinational from the register, so it stays stable until the next accepted pixel.
- **frame_done:** registered, one cycle after the last pixel of the frame is accepted. It fires even when stride skips the last pixel position.
- **Reset values:** rst zeroes all buffer entries, all counters and out_valid, out_last and frame_done, and sets state to FILL. Because out_window maps directly from the buffer, it reads 0 after reset. Reset mid-frame discards the frame.
- **Gaps:** gaps in in_valid are legal at any position and cause no state change.
- **Throughput:** one pixel per cycle, with no bubbles.

## Structure
- Shared package `lenet_pkg` holds the per-layer constants (DATA_W and the IMG_W/IMG_H/K sets for C1, C3 and C5) and the clog2 helper function.
- Sub-module `pixel_shift_reg` (parameters DEPTH and DATA_W; ports clk, rst, en, d, and a flat q bus) implements the register.
- The top level contains the counters, phases, FSM and tap wiring.

## Test plan
- **Ramp, default parameters:** 14×14 frame with pixel = row*14+col, continuous in_valid.
  - First out_valid follows pixel 30, with window {0,1,2,14,15,16,28,29,30}.
  - Exactly 144 windows in total.
  - out_last on the window {165,166,167,179,180,181,193,194,195}, together with out_row = 11 and out_col = 11.
- **Row edge:** after the window at (0,11), the next out_valid carries the window at (1,0), {14,15,16,28,29,30,42,43,44}. No window mixes columns 12/13 with columns 0/1.
- **Stride:** K = 2, STRIDE = 2, 28×28 ramp (mod 256).
  - 196 windows in total.
  - Second window = {2,3,30,31}.
  - frame_done fires once.
- **Gaps:** random in_valid at 30% duty on the default ramp. The window sequence is identical to the continuous case and out_valid never asserts in a cycle without a preceding accepted pixel.
- **Back-to-back frames:** frame 2 (ramp + 100) follows with no gap. Its first window is {100,101,102,114,115,116,128,129,130} and contains no frame-1 data.
- **Clear and reset mid-frame:**
  - Pulse clear with in_valid high at pixel 50: pixel 50 is dropped, and the next pixel is treated as (0,0).
  - Assert rst mid-frame: all outputs read 0 on the next sample, and the following frame matches the first scenario.
